fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of decode/control. It owns the fetch PC, issues sequential word requests to instruction memory, and buffers returned instructions with their PCs in a small in-order queue. It presents the instructions to decode over a valid/ready handshake. A redirect from the execute stage (taken branch, JAL, JALR) flushes the queue, discards in-flight responses and restarts fetch at the target.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, execute redirect and decode handshake.
// master = fetch_queue, slave = surrounding pipeline / memory.
interface fetch_queue_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic              imem_req_o;
   logic [AWIDTH-1:0] imem_addr_o;
   logic              imem_rvalid_i;
   logic [DWIDTH-1:0] imem_rdata_i;
   logic              redirect_i;
   logic [AWIDTH-1:0] redirect_pc_i;
   logic              insn_valid_o;
   logic              insn_ready_i;
   logic [DWIDTH-1:0] insn_o;
   logic [AWIDTH-1:0] pc_o;

   modport master (
      output imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o,
      input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o,
      output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC requests, in-order response queue to decode,
// redirect flushes the queue and turns in-flight requests into stale responses to drop.
module fetch_queue #(
   parameter int                DWIDTH   = 32,
   parameter int                AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
   parameter int                DEPTH    = 4
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 2;

   logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d, live_q, live_d, stale_q, stale_d;
   logic [DWIDTH-1:0] insn_mem [DEPTH];
   logic [AWIDTH-1:0] pc_mem   [DEPTH];

   logic              pop, issue, resp_drop, resp_push, resp_ok;
   logic [SW-1:0]     occ;
   logic [AWIDTH-1:0] redir_pc;
   logic              unused_pc_lsb;

   assign redir_pc      = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
   assign unused_pc_lsb = ^bus.redirect_pc_i[1:0];

   assign bus.insn_valid_o = (count_q != '0) & ~bus.redirect_i;
   assign pop              = bus.insn_valid_o & bus.insn_ready_i;

   // Every outstanding request (live or stale) reserves a slot, so a push can never overflow.
   assign occ   = SW'(count_q) + SW'(live_q) + SW'(stale_q) - SW'(pop);
   assign issue = rst_n & ~bus.redirect_i & (occ < SW'(DEPTH));

   assign resp_drop = bus.imem_rvalid_i & (stale_q != '0);
   assign resp_push = bus.imem_rvalid_i & (stale_q == '0) & (live_q != '0);
   assign resp_ok   = resp_drop | resp_push;

   assign bus.imem_req_o  = issue;
   assign bus.imem_addr_o = fetch_pc_q;
   assign bus.insn_o      = insn_mem[head_q];
   assign bus.pc_o        = pc_mem[head_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      live_d     = live_q;
      stale_d    = stale_q;
      if (bus.redirect_i) begin
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
         count_d    = '0;
         head_d     = tail_q;
         // A response landing this cycle is dropped here, so it no longer needs a stale slot.
         stale_d    = stale_q + live_q - CW'(resp_ok);
         live_d     = '0;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + AWIDTH'(4);
         if (resp_push) begin
            resp_pc_d = resp_pc_q + AWIDTH'(4);
            tail_d    = tail_q + PW'(1);
         end
         if (pop) head_d = head_q + PW'(1);
         count_d = count_q + CW'(resp_push) - CW'(pop);
         live_d  = live_q + CW'(issue) - CW'(resp_push);
         stale_d = stale_q - CW'(resp_drop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= BASEADDR;
         resp_pc_q  <= BASEADDR;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         live_q     <= '0;
         stale_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         live_q     <= live_d;
         stale_q    <= stale_d;
      end
   end

   // Storage needs no reset: entries are only read once count marks them valid.
   always_ff @(posedge clk) begin
      if (resp_push & ~bus.redirect_i) begin
         insn_mem[tail_q] <= bus.imem_rdata_i;
         pc_mem[tail_q]   <= resp_pc_q;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: variable-latency in-order memory, redirects and resets,
// checked against an epoch-tagged queue model of the delivered instruction stream.
module tb_fetch_queue;
   localparam int          DW    = 32;
   localparam int          AW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0100_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
   fetch_queue #(.DWIDTH(DW), .AWIDTH(AW), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [31:0] insn; logic [31:0] pc; } ent_t;

   req_t        pend[$];
   ent_t        mq[$];
   logic [31:0] m_pc;
   int          epoch, cyc, last_due, lat_min, lat_max, n_chk, n_fail, n_req;
   bit          stray, fired, rel_pend;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000 ^ {a[24:0], 7'h0};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // rmode: 0 no redirect, 1 redirect, 2 redirect only if a real response arrives this cycle
   task automatic cycle(input int rmode, input logic [31:0] rpc, input bit rdy);
      bit rv, redir, ev, ep, er;
      logic [31:0] rd;
      int occ, due;
      req_t r;
      @(posedge clk); #1;
      if (rel_pend) begin rst_n = 1'b1; rel_pend = 1'b0; end
      rv = 1'b0; rd = '0;
      if (stray) begin rv = 1'b1; rd = 32'hDEAD_BEEF; end
      else if (pend.size() != 0 && pend[0].due <= cyc) begin rv = 1'b1; rd = imem(pend[0].addr); end
      redir = (rmode == 1) || (rmode == 2 && rv && !stray);
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      bus.insn_ready_i  = rdy;
      bus.imem_rvalid_i = rv;
      bus.imem_rdata_i  = rd;
      @(negedge clk);
      ev  = mq.size() != 0 && !redir;
      ep  = ev && rdy;
      occ = mq.size() + pend.size() - int'(ep);
      er  = !redir && occ < DEPTH;
      check("req", bus.imem_req_o, er);
      if (er && bus.imem_req_o) check("addr", bus.imem_addr_o, m_pc);
      check("valid", bus.insn_valid_o, ev);
      if (ev && bus.insn_valid_o) begin
         check("pc", bus.pc_o, mq[0].pc);
         check("insn", bus.insn_o, mq[0].insn);
      end
      if (rv && !stray) r = pend.pop_front();
      if (redir) begin
         mq.delete();
         m_pc = {rpc[31:2], 2'b00};
         epoch++;
      end else begin
         if (ep) void'(mq.pop_front());
         if (rv && !stray && r.epoch == epoch) mq.push_back('{imem(r.addr), r.addr});
      end
      if (er) m_pc += 32'd4;
      if (bus.imem_req_o) begin
         n_req++;
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{bus.imem_addr_o, epoch, due});
      end
      stray = 1'b0;
      fired = redir;
      cyc++;
   endtask

   initial begin
      bit seen;
      int n0;
      logic [31:0] tgt;
      bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.insn_ready_i = 1'b0;
      bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
      m_pc = BASE; epoch = 0; cyc = 0; last_due = 0; n_chk = 0; n_fail = 0; n_req = 0;
      stray = 1'b0; fired = 1'b0; rel_pend = 1'b0;
      lat_min = 1; lat_max = 1;
      #2;
      check("rst_req", bus.imem_req_o, 1'b0);
      check("rst_valid", bus.insn_valid_o, 1'b0);
      repeat (2) @(negedge clk);
      rel_pend = 1'b1;

      // Streaming from reset, L=1, decode always ready
      cycle(0, '0, 1'b1);
      check("first_addr", bus.imem_addr_o, BASE);
      repeat (11) cycle(0, '0, 1'b1);

      // Backpressure: restart at BASE, decode stalled
      cycle(1, BASE, 1'b1);
      n0 = n_req;
      repeat (10) cycle(0, '0, 1'b0);
      check("bp_reqs", n_req - n0, 4);
      check("bp_head", bus.pc_o, BASE);
      cycle(0, '0, 1'b1);
      check("bp_resume", bus.imem_addr_o, BASE + 32'h10);
      repeat (6) cycle(0, '0, 1'b1);

      // Redirect with requests in flight, L=3
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 10 && pend.size() < 2; i++) cycle(0, '0, 1'b1);
      cycle(1, 32'h0100_0203, 1'b1);
      cycle(0, '0, 1'b1);
      check("redir_addr", bus.imem_addr_o, 32'h0100_0200);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(0, '0, 1'b1);
         if (bus.insn_valid_o && !seen) begin
            check("redir_first", bus.pc_o, 32'h0100_0200);
            seen = 1'b1;
         end
      end
      check("redir_seen", seen, 1'b1);

      // Redirect coincident with a response, then a second redirect right after
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 10 && !fired; i++) cycle(2, BASE + 32'h800, 1'b1);
      check("redir_on_resp", fired, 1'b1);
      cycle(1, BASE + 32'hC00, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, '0, 1'b1);
         if (bus.insn_valid_o && !seen) begin
            check("redir2_first", bus.pc_o, BASE + 32'hC00);
            seen = 1'b1;
         end
      end
      check("redir2_seen", seen, 1'b1);

      // Random latency 1..5, random ready, random redirects
      lat_min = 1; lat_max = 5;
      for (int i = 0; i < 1500; i++) begin
         tgt = BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
         if ($urandom_range(0, 29) == 0)      cycle(1, tgt, $urandom_range(0, 3) != 0);
         else if ($urandom_range(0, 59) == 0) cycle(2, tgt, $urandom_range(0, 3) != 0);
         else                                 cycle(0, tgt, $urandom_range(0, 3) != 0);
      end

      // Asynchronous reset mid-stream
      lat_min = 4; lat_max = 4;
      for (int i = 0; i < 10 && pend.size() < 3; i++) cycle(0, '0, 1'b1);
      check("pre_rst_inflight", pend.size() >= 3, 1'b1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      bus.redirect_i = 1'b0; bus.imem_rvalid_i = 1'b0;
      #1;
      check("arst_req", bus.imem_req_o, 1'b0);
      check("arst_valid", bus.insn_valid_o, 1'b0);
      mq.delete(); pend.delete();
      m_pc = BASE; epoch++; last_due = cyc;
      repeat (2) @(negedge clk);
      check("arst_hold_req", bus.imem_req_o, 1'b0);
      rel_pend = 1'b1;
      stray = 1'b1;
      lat_min = 1; lat_max = 1;
      cycle(0, '0, 1'b1);
      check("rst_restart", bus.imem_addr_o, BASE);
      repeat (12) cycle(0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
